timer_seq_ctrl: RTL and testbench
=================================

TIMER_SEQ_CTRL -- requirements
Module: timer_seq_ctrl

Interface
REQ-001 SHALL have parameter POLL_GAP, default 4: idle cycles between TSR polls (range 1-255).
REQ-002 SHALL have ports: sys_clk  in  1  single clock, all logic on rising edge.
REQ-003 SHALL have ports: sys_rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: cmd_valid in 1, cmd_ready out 1: command handshake, accepted when both are high on a sys_clk edge.
REQ-005 SHALL have ports: cmd_tdr in 8 (preload value), cmd_dir in 1 (0 up, 1 down), cmd_cks in 2 (clock select), cmd_periodic in 1 (auto-reload).
REQ-006 SHALL have ports: stop in 1: level request to halt the running timer.
REQ-007 SHALL have APB master ports: psel out 1, penable out 1, pwrite out 1, paddr out 8, pwdata out 8, prdata in 8, pready in 1, pslverr in 1.
REQ-008 SHALL have status ports: busy out 1, evt out 1 (one-cycle event pulse), done out 1 (one-cycle pulse), err out 1 (sticky).

Function
REQ-009 SHALL drive the timer map: TDR 0x00, TCR 0x01, TSR 0x02; TCR bits load[7], updown[5], en[4], cks[1:0]; TSR bit0 OVF, bit1 UDF.
REQ-010 SHALL perform each APB transfer as SETUP (psel=1, penable=0) for one cycle, then ACCESS (psel=1, penable=1) until pready=1; paddr/pwrite/pwdata stable across both phases.
REQ-011 SHALL deassert psel and penable in the cycle after a completed ACCESS; back-to-back transfers insert no extra idle cycle.
REQ-012 SHALL assert cmd_ready only in IDLE; psel SHALL rise in the cycle after acceptance.
REQ-013 SHALL use FSM states IDLE, WR_TDR, WR_LOAD, WR_EN, GAP, RD_TSR, WR_CLR, WR_DIS.
REQ-014 SHALL sequence: WR_TDR writes cmd_tdr to 0x00; WR_LOAD writes 0x80 to 0x01; WR_EN writes {0,0,dir,1,00,cks} to 0x01; then GAP.
REQ-015 SHALL wait exactly POLL_GAP cycles in GAP, then go to RD_TSR, which reads 0x02.
REQ-016 SHALL check flag bit (dir=0: bit0, dir=1: bit1) on prdata at RD_TSR completion; clear -> GAP; set -> pulse evt and go to WR_CLR.
REQ-017 SHALL write 0x00 to 0x02 in WR_CLR; then periodic=1 -> WR_LOAD, periodic=0 -> WR_DIS.
REQ-018 SHALL write 0x00 to 0x01 in WR_DIS, then pulse done and return to IDLE.
REQ-019 SHALL sample stop only in GAP; stop=1 there -> WR_DIS immediately; an APB transfer in flight always completes first.
REQ-020 SHALL ignore the opposite-direction flag bit.
REQ-021 SHALL latch dir, cks, periodic, tdr at acceptance; command inputs are don't-care while busy.
REQ-022 SHALL set err when pslverr=1 at a completed ACCESS, abandon the sequence and go to WR_DIS; err clears only on reset.
REQ-023 SHALL drive busy=1 in every state except IDLE.

Reset
REQ-024 SHALL on sys_rst=1 at a clock edge enter IDLE and force psel, penable, pwrite, paddr, pwdata, busy, evt, done, err to 0; cmd_ready=1 from the first cycle after reset is released.
REQ-025 SHALL on reset mid-transfer drop psel/penable at that edge without completing the transfer.

Structure
REQ-026 SHALL place register addresses, TCR/TSR bit positions and the FSM state enum in shared package timer_pkg.
REQ-027 SHALL implement APB phase sequencing in one sub-module apb_master_if (req/addr/wdata/write in, done/rdata/slverr out); the FSM issues one request per state.

Verification
REQ-028 Up one-shot: tdr=0xFA, dir=0, cks=01, periodic=0, POLL_GAP=4 -> writes 0x00<=0xFA, 0x01<=0x80, 0x01<=0x11; evt once after OVF; 0x02<=0x00, 0x01<=0x00; done one cycle; busy low after.
REQ-029 Down periodic: tdr=0x03, dir=1, periodic=1 -> evt on each UDF; after each clear, 0x01<=0x80 then 0x01<=0x31; 3 evts observed, no done.
REQ-030 Stop: periodic run, stop=1 in GAP -> next transfer is 0x01<=0x00, done pulses, cmd_ready=1.
REQ-031 Wait states: pready low 3 cycles in ACCESS -> penable held 4 cycles, signals stable, sequence order unchanged.
REQ-032 Error: pslverr=1 on WR_LOAD -> err=1, next transfer 0x01<=0x00, done pulses, err sticky until sys_rst.
REQ-033 Reset mid-ACCESS of WR_EN -> psel=0 at that edge, all outputs 0, new command accepted cleanly.

Source files
------------

// File: rtl/timer_pkg.sv
// timer_pkg: register map, control/status bit positions, FSM states
// and transfer helpers shared by the timer sequencing controller.
package timer_pkg;

  localparam logic [7:0] ADDR_TDR = 8'h00;
  localparam logic [7:0] ADDR_TCR = 8'h01;
  localparam logic [7:0] ADDR_TSR = 8'h02;

  localparam int TCR_LOAD   = 7;
  localparam int TCR_UPDOWN = 5;
  localparam int TCR_EN     = 4;

  localparam int TSR_OVF = 0;
  localparam int TSR_UDF = 1;

  typedef enum logic [2:0] {
    IDLE,
    WR_TDR,
    WR_LOAD,
    WR_EN,
    GAP,
    RD_TSR,
    WR_CLR,
    WR_DIS
  } state_e;

  typedef struct packed {
    logic       write;
    logic [7:0] addr;
    logic [7:0] wdata;
  } xfer_t;

  function automatic xfer_t wr(
    input logic [7:0] a,
    input logic [7:0] d
  );
    xfer_t x;
    x.write = 1'b1;
    x.addr  = a;
    x.wdata = d;
    return x;
  endfunction

  function automatic xfer_t rd(input logic [7:0] a);
    xfer_t x;
    x.write = 1'b0;
    x.addr  = a;
    x.wdata = 8'h00;
    return x;
  endfunction

  function automatic logic [7:0] tcr_load();
    logic [7:0] v;
    v = '0;
    v[TCR_LOAD] = 1'b1;
    return v;
  endfunction

  function automatic logic [7:0] tcr_run(
    input logic       dir,
    input logic [1:0] cks
  );
    logic [7:0] v;
    v = '0;
    v[TCR_UPDOWN] = dir;
    v[TCR_EN]     = 1'b1;
    v[1:0]        = cks;
    return v;
  endfunction

endpackage

// File: rtl/apb_master_if.sv
// apb_master_if: APB phase sequencing. The request cycle is SETUP;
// ACCESS is held until pready. Address/data come from the requester.
module apb_master_if (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] wdata_i,
  input  logic       write_i,
  output logic       done_o,
  output logic [7:0] rdata_o,
  output logic       slverr_o,
  output logic       psel_o,
  output logic       penable_o,
  output logic       pwrite_o,
  output logic [7:0] paddr_o,
  output logic [7:0] pwdata_o,
  input  logic [7:0] prdata_i,
  input  logic       pready_i,
  input  logic       pslverr_i
);

  logic access_q;

  // enter ACCESS after SETUP, leave it on the completing pready
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      access_q <= 1'b0;
    end else if (req_i) begin
      access_q <= 1'b1;
    end else if (pready_i) begin
      access_q <= 1'b0;
    end
  end

  assign psel_o    = req_i | access_q;
  assign penable_o = access_q;
  assign pwrite_o  = write_i;
  assign paddr_o   = addr_i;
  assign pwdata_o  = wdata_i;
  assign done_o    = access_q & pready_i;
  assign rdata_o   = prdata_i;
  assign slverr_o  = pslverr_i;

endmodule

// File: rtl/timer_seq_ctrl.sv
// timer_seq_ctrl: programs a timer over APB, polls its status flag,
// reloads in periodic mode and shuts the timer down on finish/stop/error.
module timer_seq_ctrl
  import timer_pkg::*;
#(
  parameter int POLL_GAP = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_tdr,
  input  logic       cmd_dir,
  input  logic [1:0] cmd_cks,
  input  logic       cmd_periodic,
  input  logic       stop,
  output logic       psel,
  output logic       penable,
  output logic       pwrite,
  output logic [7:0] paddr,
  output logic [7:0] pwdata,
  input  logic [7:0] prdata,
  input  logic       pready,
  input  logic       pslverr,
  output logic       busy,
  output logic       evt,
  output logic       done,
  output logic       err
);

  localparam logic [7:0] GAP_LAST = 8'(POLL_GAP - 1);

  state_e     state_q;
  xfer_t      xfer_q;
  logic       req_q;
  logic [7:0] gap_q;
  logic       dir_q;
  logic [1:0] cks_q;
  logic       per_q;
  logic       evt_q;
  logic       done_q;
  logic       err_q;

  logic       xdone;
  logic [7:0] rdata;
  logic       slverr;
  logic       flag;

  apb_master_if u_apb (
    .clk_i     (sys_clk),
    .rst_i     (sys_rst),
    .req_i     (req_q),
    .addr_i    (xfer_q.addr),
    .wdata_i   (xfer_q.wdata),
    .write_i   (xfer_q.write),
    .done_o    (xdone),
    .rdata_o   (rdata),
    .slverr_o  (slverr),
    .psel_o    (psel),
    .penable_o (penable),
    .pwrite_o  (pwrite),
    .paddr_o   (paddr),
    .pwdata_o  (pwdata),
    .prdata_i  (prdata),
    .pready_i  (pready),
    .pslverr_i (pslverr)
  );

  assign flag = rdata[dir_q ? TSR_UDF : TSR_OVF];

  // sequencer: one APB request issued on entry to each transfer state
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      xfer_q  <= '0;
      req_q   <= 1'b0;
      gap_q   <= '0;
      dir_q   <= 1'b0;
      cks_q   <= '0;
      per_q   <= 1'b0;
      evt_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      req_q  <= 1'b0;
      evt_q  <= 1'b0;
      done_q <= 1'b0;
      if (xdone && slverr && state_q != WR_DIS) begin
        err_q   <= 1'b1;
        state_q <= WR_DIS;
        req_q   <= 1'b1;
        xfer_q  <= wr(ADDR_TCR, 8'h00);
      end else begin
        unique case (state_q)
          IDLE: if (cmd_valid) begin
            dir_q   <= cmd_dir;
            cks_q   <= cmd_cks;
            per_q   <= cmd_periodic;
            state_q <= WR_TDR;
            req_q   <= 1'b1;
            xfer_q  <= wr(ADDR_TDR, cmd_tdr);
          end
          WR_TDR: if (xdone) begin
            state_q <= WR_LOAD;
            req_q   <= 1'b1;
            xfer_q  <= wr(ADDR_TCR, tcr_load());
          end
          WR_LOAD: if (xdone) begin
            state_q <= WR_EN;
            req_q   <= 1'b1;
            xfer_q  <= wr(ADDR_TCR, tcr_run(dir_q, cks_q));
          end
          WR_EN: if (xdone) begin
            state_q <= GAP;
            gap_q   <= GAP_LAST;
          end
          GAP: begin
            if (stop) begin
              state_q <= WR_DIS;
              req_q   <= 1'b1;
              xfer_q  <= wr(ADDR_TCR, 8'h00);
            end else if (gap_q == 8'd0) begin
              state_q <= RD_TSR;
              req_q   <= 1'b1;
              xfer_q  <= rd(ADDR_TSR);
            end else begin
              gap_q <= gap_q - 8'd1;
            end
          end
          RD_TSR: if (xdone) begin
            if (flag) begin
              evt_q   <= 1'b1;
              state_q <= WR_CLR;
              req_q   <= 1'b1;
              xfer_q  <= wr(ADDR_TSR, 8'h00);
            end else begin
              state_q <= GAP;
              gap_q   <= GAP_LAST;
            end
          end
          WR_CLR: if (xdone) begin
            req_q <= 1'b1;
            if (per_q) begin
              state_q <= WR_LOAD;
              xfer_q  <= wr(ADDR_TCR, tcr_load());
            end else begin
              state_q <= WR_DIS;
              xfer_q  <= wr(ADDR_TCR, 8'h00);
            end
          end
          WR_DIS: if (xdone) begin
            err_q   <= err_q | slverr;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign evt       = evt_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_timer_seq_ctrl.sv
// Bench for timer_seq_ctrl: randomized runs against an expected APB
// transfer list, with an abstract timer slave raising flags on chosen polls.
module tb_timer_seq_ctrl;

  localparam int P = 4;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_tdr;
  logic       cmd_dir;
  logic [1:0] cmd_cks;
  logic       cmd_periodic;
  logic       stop;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata = 8'h00;
  logic       pready = 1'b0;
  logic       pslverr = 1'b0;
  logic       busy;
  logic       evt;
  logic       done;
  logic       err;

  timer_seq_ctrl #(.POLL_GAP(P)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_tdr      (cmd_tdr),
    .cmd_dir      (cmd_dir),
    .cmd_cks      (cmd_cks),
    .cmd_periodic (cmd_periodic),
    .stop         (stop),
    .psel         (psel),
    .penable      (penable),
    .pwrite       (pwrite),
    .paddr        (paddr),
    .pwdata       (pwdata),
    .prdata       (prdata),
    .pready       (pready),
    .pslverr      (pslverr),
    .busy         (busy),
    .evt          (evt),
    .done         (done),
    .err          (err)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
    logic       w;
    int         gap;
  } xf_t;

  xf_t  exp_q[$];
  xf_t  act_q[$];
  int   kq[$];
  int   ncmp = 0;
  int   nfail = 0;
  int   evt_cyc = 0;
  int   done_cyc = 0;
  int   idle = 0;
  int   rd_cnt = 0;
  int   wait_mode = 0;
  int   hang_idx = -1;
  int   err_idx = -1;
  logic cur_dir = 1'b0;
  logic exp_err = 1'b0;
  logic s_prev_setup = 1'b0;
  logic s_prev_done = 1'b0;
  int   s_wait = 0;
  xf_t  s_cur;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic xf_t mk(input logic [7:0] a, input logic [7:0] d,
                             input logic w, input int g);
    xf_t x;
    x.a = a;
    x.d = d;
    x.w = w;
    x.gap = g;
    return x;
  endfunction

  // APB slave + protocol monitor; the timer is abstracted to
  // "flag appears on the k-th poll since the last event"
  always @(negedge sys_clk) begin
    logic [7:0] v;
    if (sys_rst) begin
      pready = 1'b0;
      pslverr = 1'b0;
      s_prev_setup = 1'b0;
      s_prev_done = 1'b0;
      idle = 0;
    end else begin
      if (evt) evt_cyc++;
      if (done) done_cyc++;
      if (s_prev_setup)
        chk("setup_to_access", {30'd0, psel, penable}, 32'd3);
      if (s_prev_done)
        chk("penable_drop", {31'd0, penable}, 32'd0);
      s_prev_setup = 1'b0;
      s_prev_done = 1'b0;
      pready = 1'b0;
      pslverr = 1'b0;
      if (psel && !penable) begin
        s_cur = mk(paddr, pwdata, pwrite, idle);
        s_prev_setup = 1'b1;
        if (act_q.size() == hang_idx) s_wait = 1000000;
        else if (wait_mode == 2) s_wait = 3;
        else if (wait_mode == 1) s_wait = $urandom_range(0, 2);
        else s_wait = 0;
      end else if (psel && penable) begin
        chk("access_hold", {15'd0, pwrite, paddr, pwdata},
            {15'd0, s_cur.w, s_cur.a, s_cur.d});
        if (s_wait > 0) begin
          s_wait--;
        end else begin
          pready = 1'b1;
          pslverr = (act_q.size() == err_idx);
          if (!s_cur.w && s_cur.a == 8'h02) begin
            rd_cnt++;
            v = 8'($urandom);
            v[cur_dir] = 1'b0;
            if (kq.size() > 0 && rd_cnt == kq[0]) begin
              v[cur_dir] = 1'b1;
              void'(kq.pop_front());
              rd_cnt = 0;
            end
            prdata = v;
          end
          act_q.push_back(s_cur);
          s_prev_done = 1'b1;
          idle = 0;
        end
      end else begin
        chk("penable_without_psel", {31'd0, penable}, 32'd0);
        if (busy) idle++;
        else idle = 0;
      end
    end
  end

  task automatic cmp_seq(input string name);
    chk($sformatf("%s.count", name), act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      chk($sformatf("%s[%0d].addr", name, i), {24'd0, act_q[i].a},
          {24'd0, exp_q[i].a});
      chk($sformatf("%s[%0d].write", name, i), {31'd0, act_q[i].w},
          {31'd0, exp_q[i].w});
      if (exp_q[i].w)
        chk($sformatf("%s[%0d].wdata", name, i), {24'd0, act_q[i].d},
            {24'd0, exp_q[i].d});
      if (exp_q[i].gap >= 0)
        chk($sformatf("%s[%0d].gap", name, i), act_q[i].gap,
            exp_q[i].gap);
    end
  endtask

  task automatic run(input string name, input logic [7:0] tdr,
                     input logic dir, input logic [1:0] cks,
                     input logic per, input int nev, input int eidx);
    xf_t        full[$];
    int         ks[$];
    int         k;
    int         budget;
    int         exp_evt;
    logic [7:0] en;
    act_q.delete();
    exp_q.delete();
    kq.delete();
    evt_cyc = 0;
    done_cyc = 0;
    rd_cnt = 0;
    cur_dir = dir;
    err_idx = eidx;
    en = 8'h10 + (dir ? 8'h20 : 8'h00) + {6'd0, cks};
    full.push_back(mk(8'h00, tdr, 1'b1, 0));
    full.push_back(mk(8'h01, 8'h80, 1'b1, 0));
    full.push_back(mk(8'h01, en, 1'b1, 0));
    for (int i = 0; i < nev; i++) begin
      k = $urandom_range(1, 3);
      ks.push_back(k);
      for (int j = 0; j < k; j++)
        full.push_back(mk(8'h02, 8'h00, 1'b0, P));
      full.push_back(mk(8'h02, 8'h00, 1'b1, 0));
      if (per) begin
        full.push_back(mk(8'h01, 8'h80, 1'b1, 0));
        full.push_back(mk(8'h01, en, 1'b1, 0));
      end
    end
    full.push_back(mk(8'h01, 8'h00, 1'b1, per ? -1 : 0));
    if (eidx >= 0) begin
      for (int i = 0; i <= eidx; i++) exp_q.push_back(full[i]);
      exp_q.push_back(mk(8'h01, 8'h00, 1'b1, 0));
      exp_evt = 0;
      exp_err = 1'b1;
    end else begin
      exp_q = full;
      exp_evt = nev;
    end
    kq = ks;
    @(negedge sys_clk);
    chk({name, ".ready_idle"}, {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_tdr = tdr;
    cmd_dir = dir;
    cmd_cks = cks;
    cmd_periodic = per;
    @(negedge sys_clk);
    chk({name, ".psel_rise"}, {31'd0, psel}, 32'd1);
    chk({name, ".busy"}, {31'd0, busy}, 32'd1);
    chk({name, ".ready_busy"}, {31'd0, cmd_ready}, 32'd0);
    cmd_valid = 1'b0;
    cmd_tdr = 8'($urandom);
    cmd_dir = 1'($urandom_range(0, 1));
    cmd_cks = 2'($urandom_range(0, 3));
    cmd_periodic = 1'($urandom_range(0, 1));
    if (per && eidx < 0) begin
      budget = 0;
      while (evt_cyc < nev && budget < 4000) begin
        @(negedge sys_clk);
        budget++;
      end
      chk({name, ".evt_timeout"}, {31'd0, evt_cyc >= nev}, 32'd1);
      chk({name, ".no_done"}, done_cyc, 32'd0);
      stop = 1'b1;
    end
    budget = 0;
    while (done_cyc < 1 && budget < 4000) begin
      @(negedge sys_clk);
      budget++;
    end
    chk({name, ".done_timeout"}, {31'd0, done_cyc >= 1}, 32'd1);
    stop = 1'b0;
    repeat (2) @(negedge sys_clk);
    chk({name, ".done_pulses"}, done_cyc, 32'd1);
    chk({name, ".evt_pulses"}, evt_cyc, exp_evt);
    chk({name, ".busy_end"}, {31'd0, busy}, 32'd0);
    chk({name, ".ready_end"}, {31'd0, cmd_ready}, 32'd1);
    chk({name, ".psel_end"}, {31'd0, psel}, 32'd0);
    chk({name, ".err"}, {31'd0, err}, {31'd0, exp_err});
    cmp_seq(name);
    err_idx = -1;
  endtask

  initial begin
    int         budget;
    logic       per;
    cmd_valid = 1'b0;
    cmd_tdr = 8'h00;
    cmd_dir = 1'b0;
    cmd_cks = 2'b00;
    cmd_periodic = 1'b0;
    stop = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("rst.psel", {31'd0, psel}, 32'd0);
    chk("rst.penable", {31'd0, penable}, 32'd0);
    chk("rst.pwrite", {31'd0, pwrite}, 32'd0);
    chk("rst.paddr_pwdata", {16'd0, paddr, pwdata}, 32'd0);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.evt_done_err", {29'd0, evt, done, err}, 32'd0);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("rst.ready", {31'd0, cmd_ready}, 32'd1);

    wait_mode = 0;
    run("up_oneshot", 8'hFA, 1'b0, 2'b01, 1'b0, 1, -1);

    wait_mode = 1;
    run("down_periodic", 8'h03, 1'b1, 2'($urandom_range(0, 3)),
        1'b1, 3, -1);

    wait_mode = 2;
    run("wait_states", 8'h42, 1'b1, 2'b10, 1'b0, 1, -1);

    wait_mode = 1;
    for (int i = 0; i < 5; i++) begin
      per = 1'($urandom_range(0, 1));
      run($sformatf("rand%0d", i), 8'($urandom),
          1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
          per, per ? $urandom_range(1, 3) : 1, -1);
    end

    run("err_load", 8'h55, 1'b0, 2'b10, 1'b1, 2, 1);
    run("err_sticky", 8'h10, 1'b1, 2'b00, 1'b0, 1, -1);
    run("err_rand", 8'($urandom), 1'b0, 2'b11, 1'b1, 1,
        $urandom_range(0, 2));
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk("err_cleared", {31'd0, err}, 32'd0);
    exp_err = 1'b0;
    sys_rst = 1'b0;
    @(negedge sys_clk);

    act_q.delete();
    kq.delete();
    evt_cyc = 0;
    done_cyc = 0;
    wait_mode = 0;
    hang_idx = 2;
    cur_dir = 1'b0;
    cmd_valid = 1'b1;
    cmd_tdr = 8'hA5;
    cmd_dir = 1'b0;
    cmd_cks = 2'b11;
    cmd_periodic = 1'b1;
    @(negedge sys_clk);
    cmd_valid = 1'b0;
    budget = 0;
    while (!(act_q.size() == 2 && penable) && budget < 200) begin
      @(negedge sys_clk);
      budget++;
    end
    chk("hang.reach", {31'd0, act_q.size() == 2 && penable}, 32'd1);
    chk("hang.xfer", {16'd0, paddr, pwdata}, {16'd0, 8'h01, 8'h13});
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk("hang.psel", {31'd0, psel}, 32'd0);
    chk("hang.penable", {31'd0, penable}, 32'd0);
    chk("hang.bus", {15'd0, pwrite, paddr, pwdata}, 32'd0);
    chk("hang.status", {28'd0, busy, evt, done, err}, 32'd0);
    hang_idx = -1;
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("hang.ready", {31'd0, cmd_ready}, 32'd1);
    run("after_reset", 8'h7E, 1'b1, 2'b10, 1'b0, 1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
